l1_cache_2way_ctrl: RTL



---
 rtl/cache_pkg.sv | 25 ++
 rtl/l1_cache_2way_ctrl_if.sv | 48 ++++
 rtl/cache_way_array.sv | 49 ++++
 rtl/l1_cache_2way_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the 2-way L1 cache.
// Exports cache_state_t plus tag/line width derivations.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_FILL,
    S_FLUSH
  } cache_state_t;

  function automatic int tag_w(
    input int addr_w,
    input int index_bits,
    input int offset_bits
  );
    return addr_w - index_bits - offset_bits;
  endfunction

  function automatic int line_w(input int offset_bits);
    return 8 * (1 << offset_bits);
  endfunction

endpackage

// File: rtl/l1_cache_2way_ctrl_if.sv
// Cache bus: request/response, flush, refill and profiling signals.
// slave = cache side, master = requester / next-level side.
interface l1_cache_2way_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int OFFSET_BITS = 3,
  parameter int CNT_W       = 16
);
  localparam int LINE_W = line_w(OFFSET_BITS);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_hit;
  logic              flush;
  logic              flush_busy;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_data;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  req_valid, req_addr, flush,
    input  mem_req_ready, mem_rsp_valid,
    input  mem_rsp_data,
    output req_ready, rsp_valid, rsp_data,
    output rsp_hit, flush_busy,
    output mem_req_valid, mem_req_addr,
    output hit_count, miss_count
  );

  modport master (
    output req_valid, req_addr, flush,
    output mem_req_ready, mem_rsp_valid,
    output mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_hit, flush_busy,
    input  mem_req_valid, mem_req_addr,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/cache_way_array.sv
// One cache way: valid/tag/data per set, async read, sync write.
// Ports: i_rd_idx -> o_valid/o_tag/o_data; i_we write; i_clr clear.
module cache_way_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 7,
  parameter int LINE_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_valid,
  output logic [TAG_W-1:0]      o_tag,
  output logic [LINE_W-1:0]     o_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [LINE_W-1:0]     i_wr_data,
  input  logic                  i_clr,
  input  logic [INDEX_BITS-1:0] i_clr_idx
);
  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid[i_clr_idx] <= 1'b0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // tag/data are deliberately not reset; valid gates them
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];

endmodule

// File: rtl/l1_cache_2way_ctrl.sv
// 2-way set-associative read-only L1 cache with LRU refill and flush.
// Ports: clk, rst_n (async low), bus (slave side of the cache interface).
module l1_cache_2way_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 3,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  l1_cache_2way_ctrl_if.slave bus
);
  localparam int TAG_W  = tag_w(ADDR_W, INDEX_BITS, OFFSET_BITS);
  localparam int LINE_W = line_w(OFFSET_BITS);
  localparam int SETS   = 1 << INDEX_BITS;

  cache_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]     r_addr;
  logic [SETS-1:0]       r_lru;
  logic                  r_flush_pend;
  logic [INDEX_BITS-1:0] r_fcnt;
  logic [CNT_W-1:0]      r_hit_cnt;
  logic [CNT_W-1:0]      r_miss_cnt;
  logic                  r_rsp_valid;
  logic                  r_rsp_hit;
  logic [7:0]            r_rsp_data;
  logic [7:0]            r_fill_byte;

  logic [TAG_W-1:0]       w_req_tag, w_reg_tag;
  logic [INDEX_BITS-1:0]  w_req_idx, w_reg_idx, w_rd_idx;
  logic [OFFSET_BITS-1:0] w_req_off, w_reg_off;

  logic              w_v [2];
  logic [TAG_W-1:0]  w_t [2];
  logic [LINE_W-1:0] w_d [2];
  logic              w_we [2];

  logic       w_hit0, w_hit1, w_hit;
  logic       w_accept, w_flush_go, w_fill;
  logic       w_victim;
  logic [7:0] w_byte0, w_byte1;
  logic       w_rsp_vld_nxt, w_rsp_hit_nxt;
  logic [7:0] w_rsp_data_nxt;

  assign w_req_tag = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign w_req_idx = bus.req_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_req_off = bus.req_addr[OFFSET_BITS-1:0];
  assign w_reg_tag = r_addr[ADDR_W-1 -: TAG_W];
  assign w_reg_idx = r_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_reg_off = r_addr[OFFSET_BITS-1:0];

  // lookup uses the live address in IDLE, victim pick the held one
  assign w_rd_idx = (r_state == S_IDLE) ? w_req_idx : w_reg_idx;

  assign w_we[0] = w_fill && !w_victim;
  assign w_we[1] = w_fill &&  w_victim;

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W),
      .LINE_W     (LINE_W)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_idx  (w_rd_idx),
      .o_valid   (w_v[g]),
      .o_tag     (w_t[g]),
      .o_data    (w_d[g]),
      .i_we      (w_we[g]),
      .i_wr_idx  (w_reg_idx),
      .i_wr_tag  (w_reg_tag),
      .i_wr_data (bus.mem_rsp_data),
      .i_clr     (r_state == S_FLUSH),
      .i_clr_idx (r_fcnt)
    );
  end

  assign w_hit0  = w_v[0] && (w_t[0] == w_req_tag);
  assign w_hit1  = w_v[1] && (w_t[1] == w_req_tag);
  assign w_hit   = w_hit0 || w_hit1;
  assign w_byte0 = w_d[0][{w_req_off, 3'b000} +: 8];
  assign w_byte1 = w_d[1][{w_req_off, 3'b000} +: 8];

  assign w_victim = !w_v[0] ? 1'b0 :
                    !w_v[1] ? 1'b1 : r_lru[w_reg_idx];

  // a flush seen in IDLE wins over a same-cycle request
  assign w_flush_go = (r_state == S_IDLE) &&
                      (r_flush_pend || bus.flush);
  assign w_accept   = (r_state == S_IDLE) && !r_flush_pend &&
                      !bus.flush && bus.req_valid;
  assign w_fill     = (r_state == S_MISS_WAIT) && bus.mem_rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_flush_go)            w_state_nxt = S_FLUSH;
        else if (w_accept && !w_hit) w_state_nxt = S_MISS_REQ;
      end
      S_MISS_REQ:  if (bus.mem_req_ready) w_state_nxt = S_MISS_WAIT;
      S_MISS_WAIT: if (bus.mem_rsp_valid) w_state_nxt = S_FILL;
      S_FILL:      w_state_nxt = S_IDLE;
      S_FLUSH:     if (&r_fcnt) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rsp_vld_nxt  = 1'b0;
    w_rsp_hit_nxt  = 1'b0;
    w_rsp_data_nxt = r_rsp_data;
    if (w_accept && w_hit) begin
      w_rsp_vld_nxt  = 1'b1;
      w_rsp_hit_nxt  = 1'b1;
      w_rsp_data_nxt = w_hit0 ? w_byte0 : w_byte1;
    end else if (r_state == S_FILL) begin
      w_rsp_vld_nxt  = 1'b1;
      w_rsp_data_nxt = r_fill_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_lru        <= '0;
      r_flush_pend <= 1'b0;
      r_fcnt       <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_data   <= '0;
      r_fill_byte  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_vld_nxt;
      r_rsp_hit   <= w_rsp_hit_nxt;
      r_rsp_data  <= w_rsp_data_nxt;

      if (w_accept && !w_hit) r_addr <= bus.req_addr;
      if (w_fill) begin
        r_fill_byte <= bus.mem_rsp_data[{w_reg_off, 3'b000} +: 8];
      end

      if (w_flush_go) begin
        r_flush_pend <= 1'b0;
      end else if (bus.flush && r_state != S_IDLE &&
                   r_state != S_FLUSH) begin
        r_flush_pend <= 1'b1;
      end

      if (w_flush_go)              r_fcnt <= '0;
      else if (r_state == S_FLUSH) r_fcnt <= r_fcnt + INDEX_BITS'(1);

      // LRU bit names the way to evict next
      if (r_state == S_FLUSH) begin
        r_lru[r_fcnt] <= 1'b0;
      end else if (w_accept && w_hit) begin
        r_lru[w_req_idx] <= w_hit0;
      end else if (w_fill) begin
        r_lru[w_reg_idx] <= ~w_victim;
      end

      if (w_accept && w_hit && !(&r_hit_cnt)) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
      if (w_accept && !w_hit && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready     = (r_state == S_IDLE) && !r_flush_pend;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_hit       = r_rsp_hit;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.flush_busy    = r_flush_pend || (r_state == S_FLUSH);
  assign bus.mem_req_valid = (r_state == S_MISS_REQ);
  assign bus.mem_req_addr  = {r_addr[ADDR_W-1:OFFSET_BITS],
                              {OFFSET_BITS{1'b0}}};
  assign bus.hit_count     = r_hit_cnt;
  assign bus.miss_count    = r_miss_cnt;

endmodule
